// File: rtl/sm_trace_buf.sv
// sm_trace_buf: circular retire-trace FIFO with trigger/post-capture FSM.
// Define SM_TRACE_OVERWRITE_EN to overwrite the oldest entry when full instead of dropping.
module sm_trace_buf #(
    parameter int DEPTH = 16,
    parameter int POST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capEn,
    input  logic [31:0]                pc,
    input  logic [31:0]                instr,
    input  logic [31:0]                regData,
    input  logic                       trig,
    input  logic                       rearm,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [31:0]                outPc,
    output logic [31:0]                outInstr,
    output logic [31:0]                outData,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 overflow,
    output logic [1:0]                 state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {S_RUN = 2'd0, S_POST = 2'd1, S_HOLD = 2'd2} state_t;
    logic [95:0] mem_q [DEPTH];
    state_t state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d, post_q, post_d;
    logic [7:0] ovf_q, ovf_d;
    logic push, pop, full, we, lost, adv;
    always_comb begin
        pop  = (count_q != '0) && outReady;
        push = capEn && (state_q == S_RUN || state_q == S_POST) && !rearm;
        full = count_q == CW'(DEPTH);
        lost = push && full && !pop;
`ifdef SM_TRACE_OVERWRITE_EN
        we  = push;
        adv = lost;
`else
        we  = push && !lost;
        adv = 1'b0;
`endif
        wptr_d  = wptr_q + AW'(we);
        rptr_d  = rptr_q + AW'(pop || adv);
        count_d = count_q + CW'(we && !adv) - CW'(pop);
        ovf_d   = ovf_q + 8'(lost && ovf_q != 8'hFF);
        state_d = state_q;
        post_d  = post_q;
        if (state_q == S_RUN && trig) begin
            if (POST == 0) begin
                state_d = S_HOLD;
            end else begin
                post_d  = CW'(POST) - CW'(push);
                state_d = (post_d == '0) ? S_HOLD : S_POST;
            end
        end else if (state_q == S_POST && push) begin
            post_d  = post_q - 1'b1;
            state_d = (post_d == '0) ? S_HOLD : S_POST;
        end
        // rearm discards everything except the lost-entry history
        if (rearm) begin
            state_d = S_RUN;
            post_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            post_q  <= post_d;
            ovf_q   <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[wptr_q] <= {pc, instr, regData};
    end
    assign {outPc, outInstr, outData} = mem_q[rptr_q];
    assign outValid = count_q != '0;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign state    = state_q;
endmodule
